// File: rtl/dmux_4way_scheduler.sv
// dmux_4way_scheduler
//   Single-entry demultiplexing scheduler. It accepts one upstream word and
//   holds it in a WIDTH-bit register. It offers that word to exactly one of
//   four downstream channels, chosen round-robin among the channels enabled
//   by mask in the cycle the word is accepted.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   upstream word available
//   in_data    upstream payload [WIDTH-1:0]
//   in_ready   word accepted this cycle when in_valid is also 1
//   mask       channel enables, bit i = channel i eligible
//   out_valid  one-hot (or zero) offer to channel i
//   out_data   held payload, shared by all channels
//   out_ready  per-channel accept, only bit sel is honoured
//   sel        channel index of the held word, 0 when idle
//   busy       1 while a word is held
//   count      (only with DMUX_SCHED_STATS_EN) four 8-bit wrapping
//              per-channel transfer counters, channel i in [8i+7:8i]
//
// Optional feature macro: DMUX_SCHED_STATS_EN
module dmux_4way_scheduler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [3:0]       mask,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [3:0]       out_ready,
  output logic [1:0]       sel,
  output logic             busy
`ifdef DMUX_SCHED_STATS_EN
  ,
  output logic [31:0]      count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             xfer;
  logic             accept;
  logic [1:0]       base;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             found;

  always_comb begin
    xfer     = (state_q == HOLD) && out_ready[sel_q];
    in_ready = !reset && (|mask) && ((state_q == IDLE) || out_ready[sel_q]);
    accept   = in_valid && in_ready;

    // A same-cycle transfer advances the pointer before the new word is
    // placed, so back-to-back words keep rotating.
    base  = xfer ? (sel_q + 2'd1) : ptr_q;
    pick  = base;
    found = 1'b0;
    idx   = base;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = base + i[1:0];
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end

    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;

    if (xfer) begin
      ptr_d   = sel_q + 2'd1;
      state_d = IDLE;
      sel_d   = '0;
    end
    if (accept) begin
      state_d = HOLD;
      sel_d   = pick;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : '0;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign busy      = (state_q == HOLD);

`ifdef DMUX_SCHED_STATS_EN
  logic [7:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (xfer) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 8'd1;
    end
  end

  assign count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_dmux_4way_scheduler.sv
module tb_dmux_4way_scheduler;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [3:0]  mask;
  logic [3:0]  out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_ready;
  logic [1:0]  sel;
  logic        busy;
`ifdef DMUX_SCHED_STATS_EN
  logic [31:0] count;
`endif

  dmux_4way_scheduler #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mask      (mask),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
`ifdef DMUX_SCHED_STATS_EN
    ,
    .count     (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One record per clock: inputs driven after the falling edge, outputs
  // expected just before the following rising edge.
  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] din;
    logic [3:0]  msk;
    logic [3:0]  ordy;
    logic        e_ir;
    logic [3:0]  e_ov;
    logic [15:0] e_od;
    logic        chk_od;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic iv, input logic [15:0] din,
                     input logic [3:0] msk, input logic [3:0] ordy,
                     input logic e_ir, input logic [3:0] e_ov,
                     input logic [15:0] e_od, input logic chk_od);
    vec_t v;
    v.rst = rst; v.iv = iv; v.din = din; v.msk = msk; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.chk_od = chk_od;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] ov2sel(input logic [3:0] ov);
    case (ov)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  initial begin
    int sent, rcv, cyc;
    logic [1:0] e_sel;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; mask = 4'hF; out_ready = 4'hF;
    repeat (2) @(negedge clk);

    // Round robin over all four channels, sustained throughput.
    add(0,0,16'h0000,4'hF,4'hF, 1,4'b0000,16'h0000,1);
    add(0,1,16'h0001,4'hF,4'hF, 1,4'b0000,16'h0000,1);
    add(0,1,16'h0002,4'hF,4'hF, 1,4'b0001,16'h0001,1);
    add(0,1,16'h0003,4'hF,4'hF, 1,4'b0010,16'h0002,1);
    add(0,1,16'h0004,4'hF,4'hF, 1,4'b0100,16'h0003,1);
    add(0,1,16'h0005,4'hF,4'hF, 1,4'b1000,16'h0004,1);
    add(0,1,16'h0006,4'hF,4'hF, 1,4'b0001,16'h0005,1);
    add(0,1,16'h0007,4'hF,4'hF, 1,4'b0010,16'h0006,1);
    add(0,1,16'h0008,4'hF,4'hF, 1,4'b0100,16'h0007,1);
    add(0,0,16'hDEAD,4'hF,4'hF, 1,4'b1000,16'h0008,1);
    add(0,0,16'hDEAD,4'hF,4'hF, 1,4'b0000,16'h0000,0);
    // Sparse mask 0101: channels 0,2,0,2.
    add(0,1,16'h00A0,4'h5,4'hF, 1,4'b0000,16'h0000,0);
    add(0,1,16'h00A1,4'h5,4'hF, 1,4'b0001,16'h00A0,1);
    add(0,1,16'h00A2,4'h5,4'hF, 1,4'b0100,16'h00A1,1);
    add(0,1,16'h00A3,4'h5,4'hF, 1,4'b0001,16'h00A2,1);
    add(0,0,16'h0000,4'h5,4'hF, 1,4'b0100,16'h00A3,1);
    add(0,0,16'h0000,4'hF,4'hF, 1,4'b0000,16'h0000,0);
    // Stall on channel 1 for five cycles, foreign ready bits ignored.
    add(0,1,16'h1234,4'h2,4'h0, 1,4'b0000,16'h0000,0);
    add(0,1,16'h5555,4'hF,4'h0, 0,4'b0010,16'h1234,1);
    add(0,1,16'h5555,4'hF,4'h0, 0,4'b0010,16'h1234,1);
    add(0,1,16'h5555,4'hF,4'h0, 0,4'b0010,16'h1234,1);
    add(0,1,16'h5555,4'hF,4'hD, 0,4'b0010,16'h1234,1);
    add(0,1,16'h5555,4'hF,4'hD, 0,4'b0010,16'h1234,1);
    add(0,1,16'h5555,4'hF,4'h2, 1,4'b0010,16'h1234,1);
    add(0,0,16'h0000,4'hF,4'hF, 1,4'b0100,16'h5555,1);
    add(0,0,16'h0000,4'hF,4'hF, 1,4'b0000,16'h0000,0);
    // Mask drops to zero while channel 3 holds a word.
    add(0,1,16'h00C3,4'hF,4'h0, 1,4'b0000,16'h0000,0);
    add(0,1,16'h0777,4'h0,4'h0, 0,4'b1000,16'h00C3,1);
    add(0,1,16'h0777,4'h0,4'h8, 0,4'b1000,16'h00C3,1);
    add(0,1,16'h0777,4'h0,4'hF, 0,4'b0000,16'h0000,0);
    add(0,1,16'h0777,4'h0,4'hF, 0,4'b0000,16'h0000,0);
    // Move the pointer off zero, then reset while holding.
    add(0,1,16'h0042,4'h4,4'h0, 1,4'b0000,16'h0000,0);
    add(0,1,16'h0043,4'hF,4'h4, 1,4'b0100,16'h0042,1);
    add(1,1,16'h0099,4'hF,4'hF, 0,4'b1000,16'h0043,1);
    add(0,0,16'h0000,4'hF,4'h0, 1,4'b0000,16'h0000,1);
    add(0,1,16'h0055,4'hF,4'h0, 1,4'b0000,16'h0000,1);
    add(0,0,16'h0000,4'hF,4'hF, 1,4'b0001,16'h0055,1);
    add(0,0,16'h0000,4'hF,4'hF, 1,4'b0000,16'h0000,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].din;
      mask = vecs[i].msk; out_ready = vecs[i].ordy;
      #1;
      e_sel = ov2sel(vecs[i].e_ov);
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d sel", i),       32'(sel),       32'(e_sel));
      chk($sformatf("v%0d busy", i),      32'(busy),      32'(|vecs[i].e_ov));
      if (vecs[i].chk_od)
        chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
    end

    // Random downstream stalls, mask 1111: words must arrive in order on
    // channels 0,1,2,3,0,... with nothing lost or duplicated.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; mask = 4'hF; out_ready = 4'h0;
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 20 && cyc < 300) begin
      @(negedge clk);
      reset = 1'b0;
      in_valid = (sent < 20);
      in_data = 16'h0100 + 16'(sent);
      out_ready = 4'($urandom_range(0, 15));
      #1;
      if (in_valid && in_ready) sent++;
      if ((out_valid & out_ready) != 4'b0000) begin
        chk($sformatf("rr%0d out_valid", rcv), 32'(out_valid), 32'(4'b0001 << (rcv % 4)));
        chk($sformatf("rr%0d out_data", rcv),  32'(out_data),  32'(16'h0100 + 16'(rcv)));
        rcv++;
      end
      cyc++;
    end
    chk("rr words delivered", 32'(rcv), 32'd20);

`ifdef DMUX_SCHED_STATS_EN
    // 260 transfers to channel 2 wrap its counter to 4.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; mask = 4'h4; out_ready = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("count after reset", count, 32'h0);
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 260 && cyc < 1000) begin
      if (cyc != 0) @(negedge clk);
      in_valid = (sent < 260);
      in_data = 16'(sent);
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid[2] && out_ready[2]) rcv++;
      cyc++;
    end
    chk("stats transfers", 32'(rcv), 32'd260);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("count wrap ch2", count, 32'h0004_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
